// File: rtl/autoc_pkg.sv
// autoc_pkg
//   Shared definitions for the autocorrelation delay path:
//   - FSM state encoding for the delay controller (IDLE, PRIME, RUN)
//   - settings-word bit positions
//   - delay clamp helper used when decoding a settings write
package autoc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int ENABLE_BIT = 31;
  localparam int ZFILL_BIT  = 30;

  // A requested delay of 0 means 1; anything above the buffer depth
  // (2^aw) is limited to the depth.
  function automatic logic [31:0] clamp_delay(input logic [31:0] raw,
                                              input int unsigned aw);
    logic [31:0] max_d;
    max_d = 32'd1 << aw;
    if (raw == 32'd0) begin
      return 32'd1;
    end else if (raw > max_d) begin
      return max_d;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/autoc_delay_ram.sv
// autoc_delay_ram
//   Simple dual-port RAM, 2^AWIDTH x WIDTH, synchronous read-first.
//   A read and write to the same address in one cycle returns the old word.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address (sampled every cycle)
//   rdata  registered read data
module autoc_delay_ram #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  // Both updates are non-blocking, so a same-address read sees the
  // pre-write contents.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/autoc_delay_ctrl.sv
// autoc_delay_ctrl
//   Runtime-programmable sample delay. Each accepted input sample is
//   written into a circular buffer; once D samples are held, every new
//   sample also reads out the one written D strobes earlier.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_stb/addr/data settings bus; data[31] enable, [30] zero_fill,
//                     [AWIDTH:0] delay D (0 -> 1, >2^AWIDTH -> 2^AWIDTH)
//   strobe_in, din    input sample and its valid strobe
//   strobe_out, dout  delayed sample and its single-cycle valid pulse
//   primed            high while the buffer holds D samples (RUN)
//   dbg_state         current FSM state (autoc_pkg encoding)
//
// Strobe semantics: there is no ready/backpressure. A sample is taken on
// every rising edge where strobe_in is high, no settings write to BASE is
// present, and the FSM is in PRIME or RUN. strobe_out is high for exactly
// one cycle per produced sample, two cycles after the input strobe cycle.
import autoc_pkg::*;

module autoc_delay_ctrl #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 6,
  parameter int BASE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] din,
  output logic             strobe_out,
  output logic [WIDTH-1:0] dout,
  output logic             primed,
  output logic [1:0]       dbg_state
);

  localparam int DW = AWIDTH + 1;
  localparam logic [AWIDTH-1:0] PTR_ONE = 1;
  localparam logic [DW-1:0]     CNT_ONE = 1;
  localparam logic [DW-1:0]     D_RESET = 1;

  logic [1:0]        state;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_addr;
  logic [DW-1:0]     fill_cnt;
  logic [DW-1:0]     delay_q;
  logic [DW-1:0]     delay_new;
  logic [31:0]       delay_clamped;
  logic              enable_q;
  logic              zfill_q;
  logic              cfg_wr;
  logic              accept;
  logic              v1;      // sample in RAM-read stage
  logic              z1;      // that sample is a zero-fill output
  logic [WIDTH-1:0]  rd_data;
  logic              unused_cfg;

  assign cfg_wr = set_stb && (set_addr == 8'(BASE));

  // A settings write in the same cycle wins and drops the sample.
  assign accept = strobe_in && !cfg_wr && enable_q &&
                  ((state == ST_PRIME) || (state == ST_RUN));

  // D = 2^AWIDTH has all-zero low bits, so read and write addresses match
  // and the read-first RAM returns the sample written 2^AWIDTH strobes ago.
  assign rd_addr = wr_ptr - delay_q[AWIDTH-1:0];

  assign delay_clamped = clamp_delay(32'(set_data[AWIDTH:0]), AWIDTH);
  assign delay_new     = delay_clamped[DW-1:0];
  assign unused_cfg    = ^{set_data[29:DW], delay_clamped[31:DW]};

  assign primed    = (state == ST_RUN);
  assign dbg_state = state;

  autoc_delay_ram #(
    .WIDTH  (WIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      delay_q    <= D_RESET;
      enable_q   <= 1'b0;
      zfill_q    <= 1'b0;
      v1         <= 1'b0;
      z1         <= 1'b0;
      strobe_out <= 1'b0;
      dout       <= '0;
    end else if (cfg_wr) begin
      // Every write restarts the buffer, even if the fields are unchanged.
      state      <= set_data[ENABLE_BIT] ? ST_PRIME : ST_IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      delay_q    <= delay_new;
      enable_q   <= set_data[ENABLE_BIT];
      zfill_q    <= set_data[ZFILL_BIT];
      v1         <= 1'b0;
      z1         <= 1'b0;
      strobe_out <= 1'b0;
      dout       <= '0;
    end else begin
      strobe_out <= v1;
      if (v1) begin
        dout <= z1 ? '0 : rd_data;
      end
      v1 <= 1'b0;
      z1 <= 1'b0;
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (state == ST_PRIME) begin
          fill_cnt <= fill_cnt + CNT_ONE;
          if ((fill_cnt + CNT_ONE) == delay_q) begin
            state <= ST_RUN;
          end
          v1 <= zfill_q;
          z1 <= 1'b1;
        end else begin
          v1 <= 1'b1;
          z1 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_autoc_delay_ctrl.sv
// tb_autoc_delay_ctrl
//   Randomized self-checking bench for autoc_delay_ctrl. The reference
//   model keeps the full history of samples since the last settings write
//   and predicts output n as history[n-D] (or zero while priming with
//   zero_fill), due two cycles after its input strobe.
module tb_autoc_delay_ctrl;

  localparam int WIDTH  = 16;
  localparam int AWIDTH = 6;
  localparam int BASE   = 0;
  localparam int DEPTH  = 1 << AWIDTH;

  logic             clk;
  logic             rst;
  logic             set_stb;
  logic [7:0]       set_addr;
  logic [31:0]      set_data;
  logic             strobe_in;
  logic [WIDTH-1:0] din;
  logic             strobe_out;
  logic [WIDTH-1:0] dout;
  logic             primed;
  logic [1:0]       dbg_state;

  autoc_delay_ctrl #(
    .WIDTH  (WIDTH),
    .AWIDTH (AWIDTH),
    .BASE   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .strobe_in  (strobe_in),
    .din        (din),
    .strobe_out (strobe_out),
    .dout       (dout),
    .primed     (primed),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [WIDTH-1:0] hist[$];
  bit               m_en = 1'b0;
  bit               m_zf = 1'b0;
  int               m_d  = 1;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_delay(input int raw);
    if (raw == 0) return 1;
    if (raw > DEPTH) return DEPTH;
    return raw;
  endfunction

  function automatic logic [31:0] make_cfg(input bit en, input bit zf,
                                           input int raw);
    logic [31:0] w;
    w = '0;
    w[31] = en;
    w[30] = zf;
    w[6:0] = 7'(raw);
    return w;
  endfunction

  // Drop every predicted output due at or after cycle c.
  task automatic flush_from(input int c);
    while (exp_cyc_q.size() > 0 && exp_cyc_q[exp_cyc_q.size()-1] >= c) begin
      void'(exp_cyc_q.pop_back());
      void'(exp_q.pop_back());
    end
  endtask

  task automatic check_outputs();
    int ecyc;
    logic [WIDTH-1:0] edata;
    check_eq("primed", 32'(primed),
             32'(m_en && (hist.size() >= m_d)));
    if (strobe_out) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(strobe_out), 32'd0);
      end else begin
        ecyc  = exp_cyc_q.pop_front();
        edata = exp_q.pop_front();
        check_eq("out_cycle", 32'(cyc), 32'(ecyc));
        check_eq("dout", 32'(dout), 32'(edata));
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      check_eq("missing_out", 32'(strobe_out), 32'd1);
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  // Checks outputs for the current cycle, then drives the next edge's
  // inputs and advances the model to what that edge will do.
  task automatic step(input bit stb, input logic [WIDTH-1:0] d,
                      input bit wr, input logic [7:0] addr,
                      input logic [31:0] data, input bit do_rst);
    int n;
    @(negedge clk);
    check_outputs();
    strobe_in = stb;
    din       = d;
    set_stb   = wr;
    set_addr  = addr;
    set_data  = data;
    rst       = do_rst;
    if (do_rst) begin
      m_en = 1'b0;
      m_zf = 1'b0;
      m_d  = 1;
      hist.delete();
      flush_from(cyc + 1);
    end else if (wr && addr == 8'(BASE)) begin
      m_en = data[31];
      m_zf = data[30];
      m_d  = model_delay(int'(data[6:0]));
      hist.delete();
      flush_from(cyc + 1);
    end else if (stb && m_en) begin
      n = hist.size();
      hist.push_back(d);
      if (n < m_d) begin
        if (m_zf) begin
          exp_q.push_back('0);
          exp_cyc_q.push_back(cyc + 2);
        end
      end else begin
        exp_q.push_back(hist[n - m_d]);
        exp_cyc_q.push_back(cyc + 2);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'(BASE), '0, 1'b0);
  endtask

  task automatic cfg(input bit en, input bit zf, input int raw);
    step(1'b0, '0, 1'b1, 8'(BASE), make_cfg(en, zf, raw), 1'b0);
  endtask

  task automatic samples_seq(input int n, input int first);
    for (int i = 0; i < n; i++)
      step(1'b1, 16'(first + i), 1'b0, 8'(BASE), '0, 1'b0);
  endtask

  task automatic samples_rand(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < gap_pct) idle(1);
      step(1'b1, 16'($urandom), 1'b0, 8'(BASE), '0, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    strobe_in = 1'b0; din = '0;

    step(1'b0, '0, 1'b0, 8'(BASE), '0, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 8'(BASE), '0, 1'b0);
    @(negedge clk);
    check_eq("rst_strobe_out", 32'(strobe_out), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_primed", 32'(primed), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    idle(3);

    // D=3, no zero fill: outputs 1..7
    cfg(1'b1, 1'b0, 3);
    samples_seq(10, 1);
    idle(4);

    // D=3, zero fill: 0,0,0,1..7
    cfg(1'b1, 1'b1, 3);
    samples_seq(10, 1);
    idle(4);

    // Full depth, continuous, across several pointer wraps
    cfg(1'b1, 1'b0, 64);
    samples_rand(200, 0);
    idle(4);

    // Clamp cases
    cfg(1'b1, 1'b0, 0);
    samples_rand(20, 30);
    cfg(1'b1, 1'b0, 100);
    samples_rand(80, 0);
    idle(4);

    // Writes to another address are ignored
    cfg(1'b1, 1'b0, 4);
    samples_rand(6, 0);
    step(1'b1, 16'h5a5a, 1'b1, 8'h05, make_cfg(1'b0, 1'b0, 9), 1'b0);
    samples_rand(6, 0);

    // Reconfigure D=5 -> D=2 with a colliding strobe
    cfg(1'b1, 1'b0, 5);
    samples_rand(15, 0);
    step(1'b1, 16'hdead, 1'b1, 8'(BASE), make_cfg(1'b1, 1'b0, 2), 1'b0);
    samples_rand(10, 0);
    idle(4);

    // Reset mid-run with samples in flight
    cfg(1'b1, 1'b1, 4);
    samples_rand(10, 0);
    step(1'b1, 16'hbeef, 1'b0, 8'(BASE), '0, 1'b1);
    samples_rand(6, 0);
    @(negedge clk);
    check_eq("idle_after_rst", 32'(dbg_state), 32'd0);
    idle(3);

    // Random mix of traffic and settings writes
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(19))
        0: cfg(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
               int'($urandom_range(127)));
        1: step(1'b1, 16'($urandom), 1'b1, 8'(BASE),
                make_cfg(1'b1, 1'($urandom_range(1)),
                         int'($urandom_range(12))), 1'b0);
        2: step(1'b1, 16'($urandom), 1'b1, 8'h11, 32'($urandom), 1'b0);
        3, 4: idle(1);
        default: step(1'b1, 16'($urandom), 1'b0, 8'(BASE), '0, 1'b0);
      endcase
    end
    idle(5);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
